// File: rtl/s2p_pkg.sv
// Shared types, parameter defaults and helpers for the serial-to-parallel frame controller.
package s2p_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    localparam int unsigned DefWidth   = 16;
    localparam int unsigned DefTimeout = 64;
    localparam int unsigned DefCntW    = 8;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/s2p_frame_ctrl_if.sv
// Serial input stream and parallel output handshake of the frame controller.
interface s2p_frame_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             din;
    logic             din_en;
    logic             sof;
    logic [WIDTH-1:0] pout;
    logic             pout_vld;
    logic             pout_rdy;

    modport master (
        output din, din_en, sof, pout_rdy,
        input  pout, pout_vld
    );

    modport slave (
        input  din, din_en, sof, pout_rdy,
        output pout, pout_vld
    );
endinterface

// File: rtl/s2p_shift_reg.sv
// MSB-first shifter; load_first restarts it with din as the only valid bit.
module s2p_shift_reg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             load_first,
    input  logic             din,
    output logic [WIDTH-1:0] sr
);

    always_ff @(posedge clk) begin
        if (clr) begin
            sr <= '0;
        end else if (load_first) begin
            sr <= {{(WIDTH-1){1'b0}}, din};
        end else if (shift_en) begin
            sr <= {sr[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/s2p_frame_ctrl.sv
// Frame FSM, bit/idle counters, output word register and valid/ready handshake.
module s2p_frame_ctrl
    import s2p_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned TIMEOUT = DefTimeout,
    parameter int unsigned CNT_W   = DefCntW
) (
    input  logic             clk,
    input  logic             clrs,
    s2p_frame_ctrl_if.slave  bus,
    output logic             busy,
    output logic             ovr,
    output logic             err_to,
    output logic             err_sync,
    output logic [CNT_W-1:0] ovr_cnt
);

    localparam int unsigned BitW  = clog2(WIDTH);
    localparam int unsigned IdleW = clog2(TIMEOUT);

    state_e           st_q, st_d;
    logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;
    logic             to_q, to_d;
    logic             sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             shift_en, load_first, sr_clr, complete;
    logic [WIDTH-1:0] sr;
    logic             unused_sr_msb;

    assign unused_sr_msb = sr[WIDTH-1];

    s2p_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift_reg (
        .clk        (clk),
        .clr        (clrs | sr_clr),
        .shift_en   (shift_en),
        .load_first (load_first),
        .din        (bus.din),
        .sr         (sr)
    );

    always_comb begin
        st_d       = st_q;
        bit_cnt_d  = bit_cnt_q;
        idle_d     = idle_q;
        pout_d     = pout_q;
        vld_d      = vld_q & ~bus.pout_rdy;
        ovr_d      = 1'b0;
        to_d       = 1'b0;
        sync_d     = 1'b0;
        cnt_d      = cnt_q;
        shift_en   = 1'b0;
        load_first = 1'b0;
        sr_clr     = 1'b0;
        complete   = 1'b0;

        case (st_q)
            StIdle: begin
                if (bus.din_en && bus.sof) begin
                    load_first = 1'b1;
                    bit_cnt_d  = BitW'(1);
                    idle_d     = '0;
                    st_d       = StShift;
                end
            end
            StShift: begin
                if (bus.din_en) begin
                    idle_d = '0;
                    if (bus.sof) begin
                        sync_d     = 1'b1;
                        load_first = 1'b1;
                        bit_cnt_d  = BitW'(1);
                    end else if (bit_cnt_q == BitW'(WIDTH - 1)) begin
                        complete  = 1'b1;
                        shift_en  = 1'b1;
                        bit_cnt_d = '0;
                        st_d      = StIdle;
                    end else begin
                        shift_en  = 1'b1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (idle_q == IdleW'(TIMEOUT - 1)) begin
                    to_d      = 1'b1;
                    sr_clr    = 1'b1;
                    bit_cnt_d = '0;
                    idle_d    = '0;
                    st_d      = StIdle;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: st_d = StIdle;
        endcase

        // An accept on the completion edge frees the register for the new word.
        if (complete) begin
            if (!vld_q || bus.pout_rdy) begin
                pout_d = {sr[WIDTH-2:0], bus.din};
                vld_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clrs) begin
            st_q      <= StIdle;
            bit_cnt_q <= '0;
            idle_q    <= '0;
            pout_q    <= '0;
            vld_q     <= 1'b0;
            ovr_q     <= 1'b0;
            to_q      <= 1'b0;
            sync_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            st_q      <= st_d;
            bit_cnt_q <= bit_cnt_d;
            idle_q    <= idle_d;
            pout_q    <= pout_d;
            vld_q     <= vld_d;
            ovr_q     <= ovr_d;
            to_q      <= to_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.pout     = pout_q;
    assign bus.pout_vld = vld_q;
    assign busy         = (st_q == StShift);
    assign ovr          = ovr_q;
    assign err_to       = to_q;
    assign err_sync     = sync_q;
    assign ovr_cnt      = cnt_q;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Self-checking bench: frame-level vector table, directed corner cases, random traffic vs. a model.
module tb_s2p_frame_ctrl;
    localparam int W  = 16;
    localparam int TO = 64;

    logic       clk;
    logic       clrs;
    logic       busy, ovr, err_to, err_sync;
    logic [7:0] ovr_cnt;

    s2p_frame_ctrl_if #(.WIDTH(W)) bus ();

    s2p_frame_ctrl #(
        .WIDTH   (W),
        .TIMEOUT (TO),
        .CNT_W   (8)
    ) dut (
        .clk      (clk),
        .clrs     (clrs),
        .bus      (bus),
        .busy     (busy),
        .ovr      (ovr),
        .err_to   (err_to),
        .err_sync (err_sync),
        .ovr_cnt  (ovr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: bits of the open frame kept in a queue.
    bit         m_q[$];
    bit         m_frame;
    int         m_idle;
    logic [W-1:0] m_pout;
    bit         m_vld;
    int         m_cnt;
    bit         e_ovr, e_to, e_sync;

    typedef struct {
        logic [W-1:0] word;
        int           gap;
        bit           rdy;
        bit           rdy_last;
        logic [W-1:0] exp_pout;
        bit           exp_vld;
        bit           exp_ovr;
        int           exp_cnt;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_frame = 0;
        m_idle  = 0;
        m_pout  = '0;
        m_vld   = 0;
        m_cnt   = 0;
        e_ovr   = 0;
        e_to    = 0;
        e_sync  = 0;
    endtask

    // Advance model and DUT by one clock, then compare every output.
    task automatic step();
        bit           complete;
        logic [W-1:0] word;
        complete = 0;
        word     = '0;
        e_ovr    = 0;
        e_to     = 0;
        e_sync   = 0;
        if (clrs) begin
            model_clear();
        end else begin
            if (bus.din_en && bus.sof) begin
                if (m_frame) e_sync = 1;
                m_q.delete();
                m_q.push_back(bus.din);
                m_frame = 1;
                m_idle  = 0;
            end else if (bus.din_en && m_frame) begin
                m_q.push_back(bus.din);
                m_idle = 0;
                if (m_q.size() == W) begin
                    foreach (m_q[i]) word = {word[W-2:0], m_q[i]};
                    complete = 1;
                    m_frame  = 0;
                    m_q.delete();
                end
            end else if (!bus.din_en && m_frame) begin
                m_idle++;
                if (m_idle == TO) begin
                    e_to    = 1;
                    m_frame = 0;
                    m_idle  = 0;
                    m_q.delete();
                end
            end
            if (complete) begin
                if (!m_vld || bus.pout_rdy) begin
                    m_pout = word;
                    m_vld  = 1;
                end else begin
                    e_ovr = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end else if (m_vld && bus.pout_rdy) begin
                m_vld = 0;
            end
        end
        @(posedge clk);
        #1;
        check("pout", 32'(bus.pout), 32'(m_pout));
        check("pout_vld", 32'(bus.pout_vld), 32'(m_vld));
        check("busy", 32'(busy), 32'(m_frame));
        check("ovr", 32'(ovr), 32'(e_ovr));
        check("err_to", 32'(err_to), 32'(e_to));
        check("err_sync", 32'(err_sync), 32'(e_sync));
        check("ovr_cnt", 32'(ovr_cnt), 32'(m_cnt));
    endtask

    task automatic drive(input bit d, input bit en, input bit s, input bit r);
        bus.din      = d;
        bus.din_en   = en;
        bus.sof      = s;
        bus.pout_rdy = r;
        step();
    endtask

    task automatic send_frame(input logic [W-1:0] word, input int gap, input bit rdy,
                              input bit rdy_last);
        for (int b = W - 1; b >= 0; b--) begin
            drive(word[b], 1'b1, b == W - 1, (b == 0) ? rdy_last : rdy);
            if (b != 0) begin
                for (int g = 1; g < gap; g++) drive(1'b0, 1'b0, 1'b0, rdy);
            end
        end
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, 1, 1'b1, 1'b1, 16'hA5C3, 1'b1, 1'b0, 0};
        vecs[1] = '{16'h5A5A, 3, 1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b0, 0};
        vecs[2] = '{16'h1234, 1, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 0};
        vecs[3] = '{16'hFFFF, 1, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b1, 1};
        vecs[4] = '{16'h0F0F, 1, 1'b0, 1'b1, 16'h0F0F, 1'b1, 1'b0, 1};

        model_clear();
        bus.din = 0; bus.din_en = 0; bus.sof = 0; bus.pout_rdy = 0;
        clrs = 1;
        step();
        step();
        check("reset pout", 32'(bus.pout), 32'h0);
        check("reset vld", 32'(bus.pout_vld), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset ovr_cnt", 32'(ovr_cnt), 32'h0);
        clrs = 0;

        // Frame-level vector table; an idle cycle follows every frame.
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].word, vecs[i].gap, vecs[i].rdy, vecs[i].rdy_last);
            check($sformatf("vec%0d pout", i), 32'(bus.pout), 32'(vecs[i].exp_pout));
            check($sformatf("vec%0d vld", i), 32'(bus.pout_vld), 32'(vecs[i].exp_vld));
            check($sformatf("vec%0d ovr", i), 32'(ovr), 32'(vecs[i].exp_ovr));
            check($sformatf("vec%0d ovr_cnt", i), 32'(ovr_cnt), 32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'h0);
            drive(1'b0, 1'b0, 1'b0, vecs[i].rdy_last);
        end
        check("vld dropped after accept", 32'(bus.pout_vld), 32'h0);

        // Timeout on the 64th idle cycle, then stray bits are ignored.
        for (int b = 0; b < 5; b++) drive(1'b1, 1'b1, b == 0, 1'b1);
        for (int k = 0; k < TO - 1; k++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("to idle63 busy", 32'(busy), 32'h1);
        check("to idle63 err_to", 32'(err_to), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("to err_to", 32'(err_to), 32'h1);
        check("to busy", 32'(busy), 32'h0);
        check("to vld", 32'(bus.pout_vld), 32'h0);
        for (int k = 0; k < 20; k++) drive(1'(k), 1'b1, 1'b0, 1'b1);
        check("stray busy", 32'(busy), 32'h0);
        check("stray vld", 32'(bus.pout_vld), 32'h0);

        // Resynchronisation: second sof after seven bits restarts the frame.
        for (int b = 0; b < 7; b++) drive(1'b1, 1'b1, b == 0, 1'b1);
        begin
            logic [W-1:0] w;
            w = 16'h0F0F;
            drive(w[W-1], 1'b1, 1'b1, 1'b1);
            check("resync err_sync", 32'(err_sync), 32'h1);
            for (int b = W - 2; b >= 0; b--) drive(w[b], 1'b1, 1'b0, 1'b1);
            check("resync pout", 32'(bus.pout), 32'h0F0F);
            check("resync vld", 32'(bus.pout_vld), 32'h1);
        end

        // Reset mid-frame with a pending word and nonzero overrun count.
        send_frame(16'hBEEF, 1, 1'b0, 1'b0);
        send_frame(16'h1111, 1, 1'b0, 1'b0);
        for (int b = 0; b < 3; b++) drive(1'b1, 1'b1, b == 0, 1'b0);
        clrs = 1;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        clrs = 0;
        check("clrs pout", 32'(bus.pout), 32'h0);
        check("clrs vld", 32'(bus.pout_vld), 32'h0);
        check("clrs busy", 32'(busy), 32'h0);
        check("clrs ovr_cnt", 32'(ovr_cnt), 32'h0);

        // Saturating overrun counter.
        send_frame(16'hC0DE, 1, 1'b0, 1'b0);
        for (int n = 0; n < 300; n++) send_frame(16'(n), 1, 1'b0, 1'b0);
        check("sat ovr_cnt", 32'(ovr_cnt), 32'd255);
        check("sat pout", 32'(bus.pout), 32'hC0DE);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic in phases of differing strobe density.
        for (int ph = 0; ph < 20; ph++) begin
            int p;
            case (ph % 4)
                0: p = 90;
                1: p = 50;
                2: p = 5;
                default: p = 0;
            endcase
            for (int c = 0; c < 200; c++) begin
                clrs = ($urandom_range(999) < 3);
                drive(1'($urandom), $urandom_range(99) < p, $urandom_range(99) < 5,
                      1'($urandom));
            end
        end
        clrs = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
